twos_serial_ctrl: RTL and testbench
===================================

Name: twos_serial_ctrl

Overview:
Sequencer for the bit-serial two's-complement datapath. It takes parallel words through a valid/ready handshake and shifts each word LSB-first into the serial complementer, driving its data input and its word-start strobe. It collects the serial result bits back into a parallel word and presents them on a valid/ready output. One word is in flight at a time; the complementer is owned entirely by this controller.

Parameters:
W, 8, word width in bits (W >= 2).
SER_LAT, 0, number of clock cycles from a bit on ser_i to the corresponding result bit on ser_y (0 = combinational datapath output); allowed range 0..3.

Ports:
t_clk  input  1  system clock; all state updates on rising edge.
r  input  1  reset, asynchronous, active-high; clears all state immediately.
in_data  input  W  parallel operand.
in_valid  input  1  operand valid.
in_ready  output  1  controller can accept an operand.
out_data  output  W  parallel two's complement of the accepted operand.
out_ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros); result equals the operand.
out_valid  output  1  out_data/out_ovf valid.
out_ready  input  1  consumer accepts the result.
ser_i  output  1  serial bit to the complementer, LSB first.
ser_start  output  1  word-start strobe to the complementer; high only during bit 0.
ser_y  input  1  serial result bit from the complementer.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (r=1, asynchronous): state=IDLE, shift/result registers=0, counters=0.
- Output values during reset: in_ready=0, out_valid=0, out_data=0, out_ovf=0, ser_i=0, ser_start=0, busy=0.
- in_ready goes to 1 on the first edge after r deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into shift register, set out_ovf_reg = (in_data == 1<<(W-1)), clear result register, issue count=0, capture count=0, go to SHIFT.
  - SHIFT: lasts exactly W cycles.
    - ser_i = shift_reg[0]; ser_start = (issue count==0); shift right each edge; issue count increments.
    - After the edge issuing bit W-1: go to DRAIN if SER_LAT>0, else go to DONE.
  - DRAIN: lasts exactly SER_LAT cycles. ser_i=0, ser_start=0. Then go to DONE.
  - DONE: out_valid=1; out_data and out_ovf stay stable until out_ready=1. On out_valid&out_ready, go to IDLE.
- Capture rule: ser_y is sampled into result bit k on the edge ending the cycle that is SER_LAT cycles after bit k was on ser_i. The capture counter runs independently of the issue counter and stops after W captures.
- in_ready=0 in SHIFT, DRAIN and DONE. No new word is accepted until the result handshake completes.
- There is no IDLE bypass: after a result handshake, a new word is accepted no earlier than the next cycle.
- Latency: the accept edge is cycle 0; out_valid rises W+SER_LAT+1 edges later.
- ser_i and ser_start are 0 outside SHIFT.
- ser_start is high exactly once per word, coincident with bit 0.
- Reset mid-operation (any state): all state is abandoned immediately with no result produced. The next accepted word starts with ser_start high.
- Widths: counters are sized ceil(log2(W+1)) bits; no wrap is possible within one word.

Test Plan:
1. W=8, SER_LAT=0, bench behavioral complementer; send 0x05 -> ser_i bits 1,0,1,0,0,0,0,0 with ser_start only on the first; out_data=0xFB, out_ovf=0, out_valid 9 edges after accept.
2. Send 0x80 -> out_data=0x80, out_ovf=1. Send 0x00 -> out_data=0x00, out_ovf=0.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and in_data=0x33 -> out_data=0xFB stable, in_ready=0 throughout. After the handshake, 0x33 is accepted and yields 0xCD.
4. Reset mid-SHIFT: assert r after 3 bits issued -> all outputs 0 within the same cycle. Then send 0x01 -> 0xFF, ser_start high on its bit 0.
5. SER_LAT=2 with a complementer delayed by two registers; send 0x01 -> out_data=0xFF, out_valid 11 edges after accept.
6. Back-to-back stream 0x01, 0x7F, 0xFE with out_ready=1 -> results 0xFF, 0x81, 0x02. in_ready rises 1 cycle after each result handshake.

Source files
------------

// File: rtl/twos_serial_ctrl.sv
// rtl/twos_serial_ctrl.sv - word-to-serial sequencer for the bit-serial two's complementer
module twos_serial_ctrl #(
    parameter int W       = 8,
    parameter int SER_LAT = 0
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ser_i,
    output logic         ser_start,
    input  logic         ser_y,
    output logic         busy
);

    localparam int            CW         = $clog2(W + 1);
    localparam logic [CW-1:0] ISSUE_LAST = CW'(W - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((SER_LAT > 0) ? (SER_LAT - 1) : 0);
    localparam logic [CW-1:0] CAP_FULL   = CW'(W);
    localparam logic [W-1:0]  MOST_NEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  shift_reg;
    logic [W-1:0]  result_reg;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] cap_cnt;
    logic          ovf_flag;
    logic          issuing;
    logic          cap_src;
    logic          cap_en;

    assign issuing   = (state == SHIFT);
    assign ser_i     = issuing & shift_reg[0];
    assign ser_start = issuing & (issue_cnt == '0);
    assign busy      = (state != IDLE);
    assign cap_en    = cap_src & (cap_cnt != CAP_FULL);

    // Delay the "bit on the wire" marker by the datapath latency so capture lines up with ser_y
    generate
        if (SER_LAT == 0) begin : g_no_lat
            assign cap_src = issuing;
        end else begin : g_lat
            logic [SER_LAT-1:0] lat_pipe;
            assign cap_src = lat_pipe[SER_LAT-1];
            // Shift register of issue markers, one stage per cycle of datapath latency
            always_ff @(posedge t_clk or posedge r) begin
                if (r) begin
                    lat_pipe <= '0;
                end else begin
                    lat_pipe <= SER_LAT'({lat_pipe, issuing});
                end
            end
        end
    endgenerate

    // Sequencer: accept a word, issue it LSB-first, wait out the latency, hold the result
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state      <= IDLE;
            shift_reg  <= '0;
            result_reg <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            ovf_flag   <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (cap_en) begin
                result_reg <= {ser_y, result_reg[W-1:1]};
                cap_cnt    <= cap_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_reg  <= in_data;
                        ovf_flag   <= (in_data == MOST_NEG);
                        result_reg <= '0;
                        issue_cnt  <= '0;
                        cap_cnt    <= '0;
                        in_ready   <= 1'b0;
                        state      <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    if (issue_cnt == ISSUE_LAST) begin
                        issue_cnt <= '0;
                        state     <= (SER_LAT > 0) ? DRAIN : DONE;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (issue_cnt == DRAIN_LAST) begin
                        issue_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= result_reg;
                        out_ovf   <= ovf_flag;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_serial_ctrl.sv
// tb/tb_twos_serial_ctrl.sv - scoreboard bench for twos_serial_ctrl at SER_LAT 0 and 2
module tb_twos_serial_ctrl;

    logic t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    logic r;

    logic [7:0] a_in_data, a_out_data;
    logic a_in_valid, a_in_ready, a_out_ovf, a_out_valid, a_out_ready;
    logic a_ser_i, a_ser_start, a_ser_y, a_busy;

    logic [7:0] b_in_data, b_out_data;
    logic b_in_valid, b_in_ready, b_out_ovf, b_out_valid, b_out_ready;
    logic b_ser_i, b_ser_start, b_ser_y, b_busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] e_a, e_b;

    twos_serial_ctrl #(.W(8), .SER_LAT(0)) dut_a (
        .t_clk(t_clk), .r(r),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ser_i(a_ser_i), .ser_start(a_ser_start), .ser_y(a_ser_y), .busy(a_busy)
    );

    twos_serial_ctrl #(.W(8), .SER_LAT(2)) dut_b (
        .t_clk(t_clk), .r(r),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ser_i(b_ser_i), .ser_start(b_ser_start), .ser_y(b_ser_y), .busy(b_busy)
    );

    // Serial complementer: pass bits through up to and including the first 1, invert after
    logic a_seen, a_seen_eff;
    assign a_seen_eff = a_ser_start ? 1'b0 : a_seen;
    assign a_ser_y    = a_ser_i ^ a_seen_eff;
    always @(posedge t_clk or posedge r) begin
        if (r) a_seen <= 1'b0;
        else   a_seen <= a_seen_eff | a_ser_i;
    end

    // Same complementer followed by two register stages
    logic b_seen, b_seen_eff, b_d1, b_d2;
    assign b_seen_eff = b_ser_start ? 1'b0 : b_seen;
    assign b_ser_y    = b_d2;
    always @(posedge t_clk or posedge r) begin
        if (r) begin
            b_seen <= 1'b0;
            b_d1   <= 1'b0;
            b_d2   <= 1'b0;
        end else begin
            b_seen <= b_seen_eff | b_ser_i;
            b_d1   <= b_ser_i ^ b_seen_eff;
            b_d2   <= b_d1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitors: pop the expected {ovf,data} on every output handshake
    always @(negedge t_clk) begin
        if (!r && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_result", 32'(a_out_data), 32'hFFFF_FFFF);
            end else begin
                e_a = q_a.pop_front();
                check("a_result", 32'({a_out_ovf, a_out_data}), 32'(e_a));
            end
        end
    end

    always @(negedge t_clk) begin
        if (!r && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_result", 32'(b_out_data), 32'hFFFF_FFFF);
            end else begin
                e_b = q_b.pop_front();
                check("b_result", 32'({b_out_ovf, b_out_data}), 32'(e_b));
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input logic [8:0] exp, input bit chk_ser, output int wait_n);
        int n;
        bit got;
        @(negedge t_clk);
        a_in_data  = d;
        a_in_valid = 1'b1;
        wait_n = 0;
        while (!a_in_ready && wait_n < 50) begin
            @(negedge t_clk);
            wait_n++;
        end
        if (!a_in_ready) begin
            check("a_accept_timeout", 32'(a_in_ready), 32'd1);
            a_in_valid = 1'b0;
            return;
        end
        q_a.push_back(exp);
        @(posedge t_clk);
        #1 a_in_valid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge t_clk);
            if (a_out_valid) begin
                got = 1'b1;
            end else begin
                if (chk_ser && n < 8) begin
                    check("a_ser_i", 32'(a_ser_i), 32'(d[n]));
                    check("a_ser_start", 32'(a_ser_start), 32'(n == 0));
                end
                @(posedge t_clk);
                n++;
            end
        end
        check("a_latency", 32'(n), 32'd9);
        check("a_in_ready_in_done", 32'(a_in_ready), 32'd0);
    endtask

    task automatic send_b(input logic [7:0] d, input logic [8:0] exp);
        int n;
        bit got;
        @(negedge t_clk);
        b_in_data  = d;
        b_in_valid = 1'b1;
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(negedge t_clk);
            n++;
        end
        if (!b_in_ready) begin
            check("b_accept_timeout", 32'(b_in_ready), 32'd1);
            b_in_valid = 1'b0;
            return;
        end
        q_b.push_back(exp);
        @(posedge t_clk);
        #1 b_in_valid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge t_clk);
            if (b_out_valid) begin
                got = 1'b1;
            end else begin
                if (n < 8) check("b_ser_start", 32'(b_ser_start), 32'(n == 0));
                @(posedge t_clk);
                n++;
            end
        end
        check("b_latency", 32'(n), 32'd11);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        r = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'({a_in_ready, b_in_ready}), 32'd0);
        check("rst_out_valid", 32'({a_out_valid, b_out_valid}), 32'd0);
        check("rst_out_data", 32'({a_out_data, b_out_data}), 32'd0);
        check("rst_out_ovf", 32'({a_out_ovf, b_out_ovf}), 32'd0);
        check("rst_ser", 32'({a_ser_i, a_ser_start, b_ser_i, b_ser_start}), 32'd0);
        check("rst_busy", 32'({a_busy, b_busy}), 32'd0);
        repeat (2) @(posedge t_clk);
        @(negedge t_clk);
        r = 1'b0;
        #1 check("in_ready_before_edge", 32'(a_in_ready), 32'd0);
        @(posedge t_clk);
        #1 check("in_ready_after_edge", 32'(a_in_ready), 32'd1);

        // Basic words, with serial bit-pattern checks on the first
        send_a(8'h05, {1'b0, 8'hFB}, 1'b1, w);
        send_a(8'h80, {1'b1, 8'h80}, 1'b0, w);
        send_a(8'h00, {1'b0, 8'h00}, 1'b0, w);

        // Backpressure in DONE with a pending operand
        @(posedge t_clk);
        #1 a_out_ready = 1'b0;
        send_a(8'h05, {1'b0, 8'hFB}, 1'b0, w);
        a_in_data  = 8'h33;
        a_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge t_clk);
            check("bp_out_data", 32'(a_out_data), 32'hFB);
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
        end
        @(posedge t_clk);
        #1 a_out_ready = 1'b1;
        send_a(8'h33, {1'b0, 8'hCD}, 1'b0, w);

        // Reset after three bits of a word have been issued
        @(negedge t_clk);
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(negedge t_clk);
            n++;
        end
        check("mid_accept_ready", 32'(a_in_ready), 32'd1);
        @(posedge t_clk);
        #1 a_in_valid = 1'b0;
        repeat (3) @(posedge t_clk);
        #2 r = 1'b1;
        #1;
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        check("mid_rst_ser", 32'({a_ser_i, a_ser_start}), 32'd0);
        check("mid_rst_outs", 32'({a_in_ready, a_out_valid, a_out_ovf, a_out_data}), 32'd0);
        @(negedge t_clk);
        r = 1'b0;
        send_a(8'h01, {1'b0, 8'hFF}, 1'b1, w);

        // Latency-2 datapath
        send_b(8'h01, {1'b0, 8'hFF});
        send_b(8'h80, {1'b1, 8'h80});

        // Back-to-back stream; in_ready returns the cycle after each handshake
        send_a(8'h01, {1'b0, 8'hFF}, 1'b0, w);
        send_a(8'h7F, {1'b0, 8'h81}, 1'b0, w);
        check("b2b_ready_gap_1", 32'(w), 32'd0);
        send_a(8'hFE, {1'b0, 8'h02}, 1'b0, w);
        check("b2b_ready_gap_2", 32'(w), 32'd0);

        repeat (3) @(negedge t_clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
